// File: rtl/din_pulse_divider.sv
// Per-channel event divider: each channel emits a one-cycle dout pulse on every
// div-th sampled din high, with a divisor latched on leaving IDLE.
module din_pulse_divider #(
  parameter int unsigned CH      = 4,
  parameter int unsigned CNT_W   = 4,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  input  logic [CH-1:0]    din,
  output logic [CH-1:0]    dout,
  output logic [CH-1:0]    busy,
  output logic [CH-1:0]    err
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e [CH-1:0]            state_q, state_d;
  logic   [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic   [CH-1:0][CNT_W-1:0] div_q, div_d;
  logic   [CH-1:0]            err_q, err_d;
  logic   [CH-1:0]            dout_q, dout_d;
  logic   [CH-1:0]            term_c;

  // Per-channel next-state; clr overrides everything, en=0 freezes the channel.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    err_d   = err_q;
    term_c  = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      term_c[c] = (state_q[c] == COUNT) && en && din[c] && !clr &&
                  (cnt_q[c] == div_q[c] - CNT_W'(1));
      if (clr) begin
        state_d[c] = IDLE;
        cnt_d[c]   = '0;
        err_d[c]   = 1'b0;
      end else if (en) begin
        unique case (state_q[c])
          IDLE: begin
            if (div != '0) begin
              state_d[c] = COUNT;
              div_d[c]   = div;
              cnt_d[c]   = '0;
            end else begin
              err_d[c] = 1'b1;
            end
          end
          COUNT: begin
            if (din[c]) begin
              cnt_d[c] = term_c[c] ? '0 : cnt_q[c] + CNT_W'(1);
            end
          end
          default: state_d[c] = IDLE;
        endcase
      end
    end
    dout_d = term_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= {CH{IDLE}};
      cnt_q   <= '0;
      div_q   <= '0;
      err_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      busy[c] = (state_q[c] == COUNT);
    end
  end

  assign dout = REG_OUT ? dout_q : term_c;
  assign err  = err_q;

endmodule
